// File: rtl/adder_pkg.sv
// Shared constants for the 4-bit adder: operand/sum widths and the
// carry-event counter limits used when ADDER_4BITS_CARRY_CNT_EN is defined.
package adder_pkg;

    localparam int unsigned ADD_W = 4;
    localparam int unsigned SUM_W = ADD_W + 1;
    localparam int unsigned CNT_W = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    // Increment that holds at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/adder_4bits_full_adder.sv
// One-bit full adder cell; adder_4bits chains four of these into a ripple-carry adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Sum and carry from the propagate term.
    always_comb begin
        p    = a ^ b;
        s    = p ^ cin;
        cout = (a & b) | (cin & p);
    end

endmodule

// File: rtl/adder_4bits.sv
// Unsigned 4-bit adder with a combinational 5-bit sum, a registered copy of the sum,
// and a registered carry-out. Defining ADDER_4BITS_CARRY_CNT_EN adds the carry_cnt
// port, an 8-bit saturating count of edges at which the carry-out was set.
module adder_4bits
    import adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    output logic [SUM_W-1:0] s,
    output logic [SUM_W-1:0] s_q,
    output logic             cout_q
`ifdef ADDER_4BITS_CARRY_CNT_EN
    ,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    // carry[i] is the carry into bit i; carry[ADD_W] is the carry-out.
    logic [ADD_W:0]   carry;
    logic [ADD_W-1:0] sum_bits;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < ADD_W; i++) begin : g_ripple
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    assign s = {carry[ADD_W], sum_bits};

    // Capture the sum every edge; reset wins over capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= '0;
        end else begin
            s_q <= s;
        end
    end

    // Carry-out is the top bit of the captured sum, so it cannot drift from s_q.
    assign cout_q = s_q[SUM_W-1];

`ifdef ADDER_4BITS_CARRY_CNT_EN
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Count edges where the live carry-out is high, holding at the maximum.
    always_comb begin
        cnt_d = cnt_q;
        if (s[SUM_W-1]) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Counter register, cleared with the rest of the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_adder_4bits.sv
// Scoreboard bench for adder_4bits. The reference model uses integer arithmetic:
// the expected sum is int(a)+int(b), and the expected count is the number of
// post-reset edges with a sum above 15, capped at 255.
module tb_adder_4bits;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] s;
    logic [4:0] s_q;
    logic       cout_q;
`ifdef ADDER_4BITS_CARRY_CNT_EN
    logic [7:0] carry_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    int comb_q[$];
    int reg_s_q[$];
    int reg_c_q[$];

    event comb_ev;

    adder_4bits u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .s         (s),
        .s_q       (s_q),
        .cout_q    (cout_q)
`ifdef ADDER_4BITS_CARRY_CNT_EN
        ,
        .carry_cnt (carry_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive operands, queue the expected sum, and let the monitor sample 1 ns later.
    task automatic apply(input logic [3:0] x, input logic [3:0] y);
        a = x;
        b = y;
        comb_q.push_back(int'(x) + int'(y));
        #1;
        -> comb_ev;
    endtask

    // Combinational monitor.
    initial begin
        forever begin
            @(comb_ev);
            if (comb_q.size() == 0) begin
                check("comb_queue_underflow", 1, 0);
            end else begin
                check("s", int'(s), comb_q.pop_front());
            end
        end
    end

    // Reference model: at each edge predict the registered state.
    initial begin
        bit known = 1'b0;
        int exp_s = 0;
        int cnt_m = 0;
        forever begin
            @(posedge clk);
            if (rst_n !== 1'b1) begin
                known = 1'b1;
                exp_s = 0;
                cnt_m = 0;
            end else if (known) begin
                exp_s = int'(a) + int'(b);
                if (exp_s > 15 && cnt_m < 255) cnt_m++;
            end
            if (known) begin
                reg_s_q.push_back(exp_s);
                reg_c_q.push_back(cnt_m);
            end
        end
    end

    // Registered monitor, sampling on the falling edge.
    initial begin
        int es;
        int ec;
        forever begin
            @(negedge clk);
            if (reg_s_q.size() > 0) begin
                es = reg_s_q.pop_front();
                ec = reg_c_q.pop_front();
                check("s_q", int'(s_q), es);
                check("cout_q", int'(cout_q), (es > 15) ? 1 : 0);
`ifdef ADDER_4BITS_CARRY_CNT_EN
                check("carry_cnt", int'(carry_cnt), ec);
`else
                if (ec < 0) check("carry_model", ec, 0);
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        apply(4'hF, 4'h1);
        // Hold reset for two edges; s must still show the live sum.
        repeat (2) begin
            @(negedge clk);
            apply(4'hF, 4'h1);
        end

        // Register latency.
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'd3, 4'd4);
        @(negedge clk);
        apply(4'd9, 4'd9);
        @(negedge clk);

        // Carry boundary.
        apply(4'b1000, 4'b1000);
        @(negedge clk);
        apply(4'b0111, 4'b1000);

        // Exhaustive sweep, one pair per cycle.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                apply(4'(i), 4'(j));
            end
        end

        // Saturation run.
        @(negedge clk);
        rst_n = 1'b0;
        apply(4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            apply(4'hF, 4'h1);
        end

        // Mid-operation reset for one edge.
        @(negedge clk);
        rst_n = 1'b0;
        apply(4'hF, 4'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with occasional resets.
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 19) != 0);
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("comb_queue_drained", comb_q.size(), 0);
        check("reg_queue_drained", reg_s_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_4bits.md
# adder_4bits

Unsigned 4-bit adder for the single-cycle MIPS datapath exercises. It produces a 5-bit sum combinationally, so downstream logic can sample the result within the same cycle. It also holds a registered copy of the sum for pipelined consumers. An optional carry-event counter can be compiled in for debug.

## Interface
Parameters:
- none; widths are fixed constants (operand 4 bits, sum 5 bits) taken from the shared package.

Ports (clock and reset first):
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- a  input  4  unsigned operand A.
- b  input  4  unsigned operand B.
- s  output  5  combinational sum a+b; bit 4 is the carry-out.
- s_q  output  5  registered sum, s captured on each rising edge.
- cout_q  output  1  registered carry-out, equal to s_q[4].
- carry_cnt  output  8  saturating count of cycles with carry-out; present only with ADDER_4BITS_CARRY_CNT_EN.

## Operation
- s = zero-extended a + zero-extended b, 5 bits wide. No truncation or wrap is possible: the maximum is 15+15 = 30 (5'b11110).
- s is implemented as a 4-stage ripple-carry chain of full adders. Carry-in to bit 0 is tied to 0.
- s depends only on the current a and b. It has no dependence on clk or rst_n, including while reset is asserted.
- X or Z on any input bit may propagate to s. With known inputs, s must never be X.
- s_q and cout_q register s and s[4] each cycle.
- carry_cnt increments by 1 on each cycle where s[4]=1 at the edge. It saturates at 255 and never wraps.

## Timing
- s has zero-cycle latency and is purely combinational. It must settle within 1 ns of any change on a or b in simulation, with no # delays in RTL.
- s_q and cout_q have one-cycle latency. They show the value of s sampled at the previous rising edge.
- Reset values, on the first rising edge with rst_n=0: s_q=5'b00000, cout_q=0, carry_cnt=0.
- Reset has priority over capture. If rst_n=0 on an edge, the registers load reset values regardless of a and b.
- Reset asserted mid-operation clears the registers on the next edge only; s is unaffected.
- The first capture happens on the first edge with rst_n=1.
- Before the first clock edge, register contents are unspecified.

## Configuration
- ADDER_4BITS_CARRY_CNT_EN defined: the carry_cnt port and its 8-bit saturating counter are present. The counter resets to 0 synchronously with rst_n.
- Not defined: the carry_cnt port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package adder_pkg holds:
  - ADD_W = 4, the operand width
  - SUM_W = ADD_W+1, the sum width
  - CNT_W = 8 and CNT_MAX = 8'hFF, for the counter
- Sub-module full_adder with 1-bit inputs a, b, cin and outputs s, cout. adder_4bits instantiates four of them via generate.
- The register stage and the counter live in adder_4bits itself.

## Test plan
- Exhaustive combinational sweep: all 256 (a,b) pairs, each held 10 ns; check s at +1 ns against a+b. Examples: a=4'b0000, b=4'b0000 -> s=5'b00000; a=4'b1111, b=4'b1111 -> s=5'b11110.
- Carry boundary: a=4'b1000, b=4'b1000 -> s=5'b10000; a=4'b0111, b=4'b1000 -> s=5'b01111.
- Reset: hold rst_n=0 for 2 edges with a=4'hF, b=4'h1 -> s_q=0, cout_q=0, carry_cnt=0, and s=5'b10000 throughout.
- Register latency: release reset, apply a=3, b=4 before an edge -> s_q=5'b00111 after that edge. Then change to a=9, b=9 -> s_q updates to 5'b10010 one edge later, and cout_q=1.
- Counter saturation (macro defined): hold a=4'hF, b=4'h1 for 300 edges -> carry_cnt reaches 255 and stays 255. Assert rst_n=0 for one edge -> carry_cnt=0.
- Macro undefined: build without ADDER_4BITS_CARRY_CNT_EN and rerun the sweep and latency tests -> identical results, and no carry_cnt port.
